// File: rtl/hmmm_pkg.sv
// rtl/hmmm_pkg.sv - shared HMMM types for the core and the I/O port
package hmmm_pkg;

    localparam int HMMM_WORD = 16;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_MUL,
        ALU_DIV,
        ALU_MOD,
        ALU_NEG,
        ALU_PASS
    } alu_op_t;

    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] rx;
        logic [3:0] ry;
        logic [3:0] rz;
    } instr_t;

    typedef enum logic [1:0] {
        IO_RUN,
        IO_DRAIN,
        IO_DONE
    } io_state_t;

endpackage

// File: rtl/hmmm_io_fifo.sv
// rtl/hmmm_io_fifo.sv - show-ahead FIFO with separate occupancy count
module hmmm_io_fifo
    import hmmm_pkg::*;
#(
    parameter int WIDTH = HMMM_WORD,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage is deliberately left unreset; head masks stale contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hmmm_io_port.sv
// rtl/hmmm_io_port.sv - READ/WRITE responder with host FIFOs and drain-on-HALT
module hmmm_io_port
    import hmmm_pkg::*;
#(
    parameter int WIDTH     = HMMM_WORD,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              rd_req,
    output logic [WIDTH-1:0]                  rd_data,
    output logic                              rd_stall,
    input  logic                              wr_req,
    input  logic [WIDTH-1:0]                  wr_data,
    output logic                              wr_stall,
    input  logic                              halt_req,
    output logic                              halt_done,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WIDTH-1:0]                  in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [WIDTH-1:0]                  out_data,
    output logic [$clog2(IN_DEPTH+1)-1:0]     in_count,
    output logic [$clog2(OUT_DEPTH+1)-1:0]    out_count
);

    io_state_t state;

    logic core_en;
    logic in_full, in_empty, out_full, out_empty;
    logic in_push, in_pop, wr_eff, out_push, out_pop;

    // Once halted the core side is frozen; the host side keeps working.
    assign core_en  = (state != IO_DONE);
    assign in_push  = in_valid && !in_full;
    assign in_pop   = core_en && rd_req && !in_empty;
    assign wr_eff   = core_en && wr_req && !rd_req;
    assign out_push = wr_eff && !out_full;
    assign out_pop  = out_ready && !out_empty;

    assign in_ready  = !in_full;
    assign rd_stall  = core_en && rd_req && in_empty;
    assign wr_stall  = wr_eff && out_full;
    assign out_valid = !out_empty;

    hmmm_io_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (IN_DEPTH)
    ) u_in_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_push),
        .push_data (in_data),
        .pop       (in_pop),
        .head      (rd_data),
        .full      (in_full),
        .empty     (in_empty),
        .count     (in_count)
    );

    hmmm_io_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (out_push),
        .push_data (wr_data),
        .pop       (out_pop),
        .head      (out_data),
        .full      (out_full),
        .empty     (out_empty),
        .count     (out_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IO_RUN;
            halt_done <= 1'b0;
        end else begin
            halt_done <= (state == IO_DONE);
            case (state)
                IO_RUN: begin
                    if (halt_req) begin
                        state <= out_empty ? IO_DONE : IO_DRAIN;
                    end
                end
                IO_DRAIN: begin
                    if (!halt_req) begin
                        state <= IO_RUN;
                    end else if (out_empty) begin
                        state <= IO_DONE;
                    end
                end
                IO_DONE: state <= IO_DONE;
                default: state <= IO_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_hmmm_io_port.sv
// tb/tb_hmmm_io_port.sv - directed and random checks of hmmm_io_port against a queue model
module tb_hmmm_io_port;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd_req = 1'b0;
    logic [15:0] rd_data;
    logic        rd_stall;
    logic        wr_req = 1'b0;
    logic [15:0] wr_data = '0;
    logic        wr_stall;
    logic        halt_req = 1'b0;
    logic        halt_done;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [2:0]  in_count;
    logic [2:0]  out_count;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] in_q[$];
    logic [15:0] out_q[$];
    int          hstate;     // 0 running, 1 waiting for output to drain, 2 halted
    bit          hdone;

    always #5 clk = ~clk;

    hmmm_io_port #(
        .WIDTH     (16),
        .IN_DEPTH  (4),
        .OUT_DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_req    (rd_req),
        .rd_data   (rd_data),
        .rd_stall  (rd_stall),
        .wr_req    (wr_req),
        .wr_data   (wr_data),
        .wr_stall  (wr_stall),
        .halt_req  (halt_req),
        .halt_done (halt_done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .in_count  (in_count),
        .out_count (out_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        in_q.delete();
        out_q.delete();
        hstate = 0;
        hdone  = 1'b0;
    endtask

    // One clock: compare every output with the model mid-cycle, then advance the model.
    task automatic cycle();
        bit          halted, acc_in, pop_in, push_out, pop_out;
        logic [15:0] exp_rd, exp_out;
        int          osz;
        @(negedge clk);
        halted  = (hstate == 2);
        exp_rd  = (in_q.size() > 0) ? in_q[0] : 16'h0;
        exp_out = (out_q.size() > 0) ? out_q[0] : 16'h0;
        chk("in_ready",  in_ready,  in_q.size() != 4);
        chk("in_count",  in_count,  in_q.size());
        chk("rd_data",   rd_data,   exp_rd);
        chk("rd_stall",  rd_stall,  rd_req && !halted && in_q.size() == 0);
        chk("wr_stall",  wr_stall,  wr_req && !rd_req && !halted && out_q.size() == 4);
        chk("out_valid", out_valid, out_q.size() != 0);
        chk("out_data",  out_data,  exp_out);
        chk("out_count", out_count, out_q.size());
        chk("halt_done", halt_done, hdone);
        acc_in   = in_valid && in_q.size() < 4;
        pop_in   = rd_req && !halted && in_q.size() > 0;
        push_out = wr_req && !rd_req && !halted && out_q.size() < 4;
        pop_out  = out_ready && out_q.size() > 0;
        osz      = out_q.size();
        @(posedge clk);
        #1;
        if (pop_in)   void'(in_q.pop_front());
        if (acc_in)   in_q.push_back(in_data);
        if (pop_out)  void'(out_q.pop_front());
        if (push_out) out_q.push_back(wr_data);
        hdone = (hstate == 2);
        if (hstate == 0 && halt_req)      hstate = (osz == 0) ? 2 : 1;
        else if (hstate == 1 && !halt_req) hstate = 0;
        else if (hstate == 1 && osz == 0)  hstate = 2;
    endtask

    task automatic idle_inputs();
        rd_req = 0; wr_req = 0; halt_req = 0; in_valid = 0; out_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #2;
        do_reset();
        #1;
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_count",  in_count,  0);
        chk("rst_out_count", out_count, 0);
        chk("rst_halt_done", halt_done, 0);
        chk("rst_rd_data",   rd_data,   0);
        chk("rst_out_data",  out_data,  0);

        // Fill the input FIFO from a host that never drops in_valid.
        in_valid = 1;
        for (int k = 0; k < 5; k++) begin
            in_data = 16'h0005 + 16'(2 * in_q.size());
            cycle();
        end
        chk("fill_in_ready", in_ready, 0);
        chk("fill_in_count", in_count, 4);
        chk("fill_in_data",  in_data,  16'h000D);
        rd_req = 1;
        #1;
        chk("full_pop_no_passthru", in_ready, 0);
        chk("full_pop_head", rd_data, 16'h0005);
        cycle();
        cycle();
        in_valid = 0;
        for (int k = 0; k < 5; k++) cycle();
        rd_req = 0;

        // READ on an empty FIFO while the host pushes: no bypass.
        rd_req = 1; in_valid = 1; in_data = 16'h002A;
        #1;
        chk("nobypass_stall", rd_stall, 1);
        cycle();
        in_valid = 0;
        #1;
        chk("nobypass_next_stall", rd_stall, 0);
        chk("nobypass_next_data",  rd_data,  16'h002A);
        cycle();
        rd_req = 0;
        #1;
        chk("nobypass_empty", in_count, 0);
        cycle();

        // Fill the output FIFO, then a fifth WRITE must stall until a pop lands.
        wr_req = 1;
        for (int k = 1; k <= 4; k++) begin
            wr_data = 16'(k * 16'h1111);
            cycle();
        end
        wr_data = 16'h5555;
        #1;
        chk("wr5_stall", wr_stall, 1);
        cycle();
        out_ready = 1;
        #1;
        chk("wr5_first_out", out_data, 16'h1111);
        chk("wr5_still_stall", wr_stall, 1);
        cycle();
        #1;
        chk("wr5_unstall", wr_stall, 0);
        cycle();
        wr_req = 0;
        for (int k = 0; k < 5; k++) cycle();

        // Halt with two words pending, then drain them.
        out_ready = 0; wr_req = 1;
        wr_data = 16'hA001; cycle();
        wr_data = 16'hA002; cycle();
        wr_req = 0; halt_req = 1;
        cycle();
        cycle();
        chk("drain_halt_done", halt_done, 0);
        out_ready = 1;
        cycle();
        cycle();
        chk("drain_out_empty", out_count, 0);
        chk("drain_not_done_yet", halt_done, 0);
        cycle();
        chk("done_entry_halt_done", halt_done, 0);
        cycle();
        chk("done_halt_done", halt_done, 1);
        rd_req = 1;
        cycle();
        rd_req = 0; wr_req = 1; wr_data = 16'hBEEF;
        cycle();
        wr_req = 0; halt_req = 0; in_valid = 1; in_data = 16'h0123;
        cycle();
        in_valid = 0;
        cycle();

        // Asynchronous reset in the middle of a drain.
        do_reset();
        in_valid = 1; wr_req = 1; out_ready = 0;
        in_data = 16'h0031; wr_data = 16'h0B01; cycle();
        in_data = 16'h0032; wr_data = 16'h0B02; cycle();
        in_data = 16'h0033; wr_req = 0;         cycle();
        in_valid = 0; halt_req = 1;
        cycle();
        chk("pre_rst_in_count",  in_count,  3);
        chk("pre_rst_out_count", out_count, 2);
        #2;
        reset = 1'b0;
        #1;
        chk("async_in_count",  in_count,  0);
        chk("async_out_count", out_count, 0);
        chk("async_out_valid", out_valid, 0);
        chk("async_in_ready",  in_ready,  1);
        chk("async_halt_done", halt_done, 0);
        chk("async_rd_data",   rd_data,   0);
        do_reset();
        halt_req = 1;
        cycle();
        cycle();
        chk("post_rst_run_state", halt_done, 1);
        do_reset();

        // Read and push every cycle; pointers wrap many times.
        rd_req = 1; in_valid = 1;
        for (int k = 1; k <= 21; k++) begin
            in_data  = 16'(k);
            in_valid = (k <= 20);
            cycle();
            chk("interleave_count_le1", in_count <= 1, 1);
        end
        idle_inputs();
        cycle();

        // Random traffic on both sides.
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            in_data   = 16'($urandom);
            wr_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 99) < 50);
            case ($urandom_range(0, 9))
                0, 1, 2: begin rd_req = 1; wr_req = 0; end
                3, 4, 5: begin rd_req = 0; wr_req = 1; end
                6:       begin rd_req = 1; wr_req = 1; end
                default: begin rd_req = 0; wr_req = 0; end
            endcase
            cycle();
        end
        idle_inputs();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
